pipe_seg_reg: RTL and testbench
===============================

Name: pipe_seg_reg

Overview:
- Generic pipeline segment register that carries one instruction's payload between two pipeline stages using a valid/ready handshake.
- Generalises the fixed-field single-entry stage registers:
  - payload width is a parameter;
  - the stage's own completion signal (ready_go) is an input;
  - downstream backpressure and a synchronous flush are supported;
  - an optional skid entry registers in_ready, which breaks the combinational ready chain;
  - a saturating stall counter is included.
- One instance sits in front of each pipeline stage (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, payload width in bits. Callers concatenate all stage fields into this vector.
- SKID, 0. 0 = single entry, with in_ready combinational from out_ready. 1 = main entry plus skid entry, with in_ready a register output.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  held beat valid and stage work done
- out_ready  in  1  downstream can accept
- out_data  out  DATA_W  held payload (main entry)
- ready_go  in  1  this stage's combinational work on out_data is complete
- flush  in  1  discard all held and incoming beats at this edge
- busy  out  1  main entry valid, irrespective of ready_go
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: valid and skid_valid are 0, data registers are 0, and stall_cnt is 0. After reset, out_valid = 0, busy = 0, out_data = 0. in_ready = 1 in both modes.
- out_valid = valid & ready_go. busy = valid.
- out_fire = out_valid & out_ready. in_fire = in_valid & in_ready.
- Data registers load only on their enable; they are never cleared by flush.
- SKID=0:
  - in_ready = !valid | (ready_go & out_ready).
  - On in_fire: main_data <= in_data.
  - Next valid:
    - if in_ready: valid <= in_valid;
    - otherwise valid holds.
  - Latency is 1 cycle. Throughput is 1 beat/cycle when downstream is ready.
- SKID=1 (in_ready = !skid_valid, registered). Next-state rules:
  - Main empty or out_fire, skid_valid = 1: main <= skid, skid_valid <= 0. No in_fire is possible this cycle.
  - Main empty or out_fire, skid_valid = 0: main_data <= in_data; valid <= in_fire.
  - Main held (valid & !out_fire) and in_fire: skid_data <= in_data, skid_valid <= 1.
  - Main held and no in_fire: hold.
  - Order is always preserved. Latency is 1 cycle. Full throughput with in_ready registered. At most 2 beats are held.
- Flush:
  - Priority over every valid update: valid <= 0 and skid_valid <= 0 at the edge.
  - A beat accepted on the flush cycle (in_fire = 1) is discarded.
  - out_valid and in_ready are not gated by flush during that cycle. Upstream/downstream flush handling covers beats crossing the boundary.
- Reset mid-operation: identical to flush, plus data registers and stall_cnt are zeroed.
- Stall counter:
  - Increments when valid & !(ready_go & out_ready).
  - Saturates at all-ones.
  - cnt_clr zeroes it and has priority over increment.
  - rst has priority over all.
- ready_go = 0 with valid = 1:
  - stage holds;
  - SKID=0: in_ready = 0;
  - SKID=1: one more beat is accepted into skid, then in_ready drops.

Test Plan:
- SKID=0, DATA_W=32, ready_go = 1, out_ready = 1, in_valid every cycle, in_data = 0x10, 0x11, 0x12 -> out_data sequence is 0x10, 0x11, 0x12 one cycle later, out_valid continuous, stall_cnt = 0.
- SKID=0, held beat 0xA5A5A5A5, out_ready = 0 for 3 cycles -> in_ready = 0 for those 3 cycles, out_data stable, stall_cnt = 3. Then out_ready = 1 -> beat delivered once, in_ready = 1 in that same cycle.
- SKID=1, stream 0x1, 0x2, 0x3, 0x4, out_ready dropped for 1 cycle during 0x2 -> skid_valid = 1, next cycle in_ready = 0. Output order is 0x1, 0x2, 0x3, 0x4 with no loss or duplication.
- SKID=1, both entries full (0x7 main, 0x8 skid), flush = 1 -> next cycle out_valid = 0, busy = 0, in_ready = 1. Neither 0x7 nor 0x8 appears afterwards.
- ready_go = 0 for 2 cycles while valid, out_ready = 1 -> out_valid = 0, stall_cnt += 2. Then ready_go = 1 -> out_valid = 1 with the original data.
- CNT_W = 2, 5 stalled cycles -> stall_cnt reads 1, 2, 3, 3, 3. cnt_clr together with a stall -> stall_cnt = 0 next cycle. rst asserted mid-stream -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pipe_seg_reg.sv
// Generic valid/ready pipeline segment register with optional skid entry
// and a saturating stall counter.
module pipe_seg_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              ready_go,
  input  logic              flush,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid;
  logic [DATA_W-1:0] main_data;
  logic              out_fire;
  logic              in_fire;
  logic              stall;

  assign out_valid = valid & ready_go;
  assign busy      = valid;
  assign out_data  = main_data;
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready;
  assign stall     = valid & ~(ready_go & out_ready);

  generate
    if (SKID == 0) begin : g_single
      assign in_ready = ~valid | (ready_go & out_ready);

      always_ff @(posedge clk) begin
        if (rst) begin
          valid     <= 1'b0;
          main_data <= '0;
        end else begin
          if (flush)
            valid <= 1'b0;
          else if (in_ready)
            valid <= in_valid;
          if (in_fire)
            main_data <= in_data;
        end
      end
    end else begin : g_skid
      logic              skid_valid;
      logic [DATA_W-1:0] skid_data;
      logic              advance;

      // Ready depends only on state, so no comb path from out_ready.
      assign in_ready = ~skid_valid;
      assign advance  = ~valid | out_fire;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid      <= 1'b0;
          skid_valid <= 1'b0;
          main_data  <= '0;
          skid_data  <= '0;
        end else begin
          if (advance) begin
            if (skid_valid) begin
              main_data  <= skid_data;
              valid      <= 1'b1;
              skid_valid <= 1'b0;
            end else begin
              if (in_fire)
                main_data <= in_data;
              valid <= in_fire;
            end
          end else if (in_fire) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
          end
          if (flush) begin
            valid      <= 1'b0;
            skid_valid <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (cnt_clr)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Bench for pipe_seg_reg: single-entry, skid and narrow-counter instances
// driven in lockstep and checked against a queue-based reference.
module tb_pipe_seg_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        ready_go;
  logic        flush;
  logic        cnt_clr;

  logic        ir0, ov0, bz0;
  logic [31:0] od0, sc0;
  logic        ir1, ov1, bz1;
  logic [31:0] od1, sc1;
  logic        ir2, ov2, bz2;
  logic [31:0] od2;
  logic [1:0]  sc2;

  int checks = 0;
  int errors = 0;

  pipe_seg_reg #(.DATA_W(32), .SKID(0), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .ready_go(ready_go), .flush(flush), .busy(bz0),
    .cnt_clr(cnt_clr), .stall_cnt(sc0)
  );

  pipe_seg_reg #(.DATA_W(32), .SKID(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .ready_go(ready_go), .flush(flush), .busy(bz1),
    .cnt_clr(cnt_clr), .stall_cnt(sc1)
  );

  pipe_seg_reg #(.DATA_W(32), .SKID(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .ready_go(ready_go), .flush(flush), .busy(bz2),
    .cnt_clr(cnt_clr), .stall_cnt(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each instance is a FIFO of held beats (depth 1 or 2).
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mc0, mc1;
  logic [1:0]  mc2;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    mq0.delete();
    mq1.delete();
    mc0 = 0;
    mc1 = 0;
    mc2 = 0;
  endtask

  task automatic mstep();
    bit go, mir0, mir1, st0, st1, f0o, f0i, f1o, f1i;
    go   = ready_go && out_ready;
    mir0 = (mq0.size() == 0) || go;
    mir1 = (mq1.size() < 2);
    chk("u0_in_ready", ir0, mir0);
    chk("u0_out_valid", ov0, mq0.size() > 0 && ready_go);
    chk("u0_busy", bz0, mq0.size() > 0);
    if (mq0.size() > 0) chk("u0_out_data", od0, mq0[0]);
    chk("u0_stall_cnt", sc0, mc0);
    chk("u2_in_ready", ir2, mir0);
    chk("u2_out_valid", ov2, mq0.size() > 0 && ready_go);
    if (mq0.size() > 0) chk("u2_out_data", od2, mq0[0]);
    chk("u2_stall_cnt", sc2, mc2);
    chk("u1_in_ready", ir1, mir1);
    chk("u1_out_valid", ov1, mq1.size() > 0 && ready_go);
    chk("u1_busy", bz1, mq1.size() > 0);
    if (mq1.size() > 0) chk("u1_out_data", od1, mq1[0]);
    chk("u1_stall_cnt", sc1, mc1);
    st0 = mq0.size() > 0 && !go;
    st1 = mq1.size() > 0 && !go;
    f0o = mq0.size() > 0 && go;
    f1o = mq1.size() > 0 && go;
    f0i = in_valid && mir0;
    f1i = in_valid && mir1;
    if (f0o) void'(mq0.pop_front());
    if (f0i) mq0.push_back(in_data);
    if (f1o) void'(mq1.pop_front());
    if (f1i) mq1.push_back(in_data);
    if (flush || rst) begin
      mq0.delete();
      mq1.delete();
    end
    if (rst || cnt_clr) begin
      mc0 = 0;
      mc1 = 0;
      mc2 = 0;
    end else begin
      if (st0 && mc0 != 32'hffff_ffff) mc0 = mc0 + 1;
      if (st0 && mc2 != 2'd3) mc2 = mc2 + 1;
      if (st1 && mc1 != 32'hffff_ffff) mc1 = mc1 + 1;
    end
  endtask

  task automatic drive(bit r, bit iv, logic [31:0] d,
                       bit o, bit g, bit f, bit c);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = o;
    ready_go  = g;
    flush     = f;
    cnt_clr   = c;
  endtask

  typedef struct {
    bit          rst, iv;
    logic [31:0] d;
    bit          ordy, rg, fl, clr;
    bit          e_ir, e_ov, e_bz, e_dchk;
    logic [31:0] e_d;
    logic [31:0] e_cnt;
    logic [1:0]  e_cnt2;
  } vec_t;

  function automatic vec_t mk(
    bit r, bit iv, logic [31:0] d, bit o, bit g, bit f, bit c,
    bit ir, bit ov, bit bz, bit dc, logic [31:0] ed,
    logic [31:0] ec, logic [1:0] ec2);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = o; v.rg = g;
    v.fl = f; v.clr = c; v.e_ir = ir; v.e_ov = ov; v.e_bz = bz;
    v.e_dchk = dc; v.e_d = ed; v.e_cnt = ec; v.e_cnt2 = ec2;
    return v;
  endfunction

  vec_t        tbl[25];
  logic [31:0] src[$];
  logic [31:0] got[$];

  initial begin
    bit pi;
    tbl[0]  = mk(0,1,32'h10,1,1,0,0, 1,0,0,0,0,0,0);
    tbl[1]  = mk(0,1,32'h11,1,1,0,0, 1,1,1,1,32'h10,0,0);
    tbl[2]  = mk(0,1,32'h12,1,1,0,0, 1,1,1,1,32'h11,0,0);
    tbl[3]  = mk(0,0,32'h0,1,1,0,0,  1,1,1,1,32'h12,0,0);
    tbl[4]  = mk(0,1,32'hA5A5A5A5,1,1,0,0, 1,0,0,0,0,0,0);
    tbl[5]  = mk(0,1,32'hBB,0,1,0,0, 0,1,1,1,32'hA5A5A5A5,0,0);
    tbl[6]  = mk(0,1,32'hBB,0,1,0,0, 0,1,1,1,32'hA5A5A5A5,1,1);
    tbl[7]  = mk(0,1,32'hBB,0,1,0,0, 0,1,1,1,32'hA5A5A5A5,2,2);
    tbl[8]  = mk(0,1,32'hBB,1,1,0,0, 1,1,1,1,32'hA5A5A5A5,3,3);
    tbl[9]  = mk(0,0,32'h0,1,1,0,0,  1,1,1,1,32'hBB,3,3);
    tbl[10] = mk(0,1,32'h55,1,1,0,0, 1,0,0,0,0,3,3);
    tbl[11] = mk(0,0,32'h0,1,0,0,0,  0,0,1,1,32'h55,3,3);
    tbl[12] = mk(0,0,32'h0,1,0,0,0,  0,0,1,1,32'h55,4,3);
    tbl[13] = mk(0,0,32'h0,1,1,0,0,  1,1,1,1,32'h55,5,3);
    tbl[14] = mk(0,1,32'h66,0,1,0,0, 1,0,0,0,0,5,3);
    tbl[15] = mk(0,0,32'h0,0,1,0,1,  0,1,1,1,32'h66,5,3);
    tbl[16] = mk(0,0,32'h0,0,1,0,0,  0,1,1,1,32'h66,0,0);
    tbl[17] = mk(0,0,32'h0,1,1,0,0,  1,1,1,1,32'h66,1,1);
    tbl[18] = mk(0,1,32'h77,1,1,0,0, 1,0,0,0,0,1,1);
    tbl[19] = mk(0,1,32'h78,0,1,1,0, 0,1,1,1,32'h77,1,1);
    tbl[20] = mk(0,1,32'h79,1,1,1,0, 1,0,0,0,0,2,2);
    tbl[21] = mk(0,0,32'h0,1,1,0,0,  1,0,0,0,0,2,2);
    tbl[22] = mk(0,1,32'h88,1,1,0,0, 1,0,0,0,0,2,2);
    tbl[23] = mk(1,1,32'h89,1,1,0,0, 1,1,1,1,32'h88,2,2);
    tbl[24] = mk(0,0,32'h0,1,1,0,0,  1,0,0,1,32'h0,0,0);

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    mreset();
    chk("rst_u0_in_ready", ir0, 1);
    chk("rst_u0_out_valid", ov0, 0);
    chk("rst_u0_busy", bz0, 0);
    chk("rst_u0_out_data", od0, 0);
    chk("rst_u0_stall_cnt", sc0, 0);
    chk("rst_u1_in_ready", ir1, 1);
    chk("rst_u1_out_valid", ov1, 0);
    chk("rst_u1_busy", bz1, 0);
    chk("rst_u1_out_data", od1, 0);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy,
            tbl[i].rg, tbl[i].fl, tbl[i].clr);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), ir0, tbl[i].e_ir);
      chk($sformatf("tbl%0d_out_valid", i), ov0, tbl[i].e_ov);
      chk($sformatf("tbl%0d_busy", i), bz0, tbl[i].e_bz);
      if (tbl[i].e_dchk)
        chk($sformatf("tbl%0d_out_data", i), od0, tbl[i].e_d);
      chk($sformatf("tbl%0d_stall_cnt", i), sc0, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_stall_cnt2", i), sc2, tbl[i].e_cnt2);
      mstep();
      @(negedge clk);
    end

    // Skid entry absorbs one beat while downstream stalls.
    src = '{32'h1, 32'h2, 32'h3, 32'h4};
    got.delete();
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      drive(0, src.size() > 0, src.size() > 0 ? src[0] : 32'h0,
            c != 2, 1, 0, 0);
      #1;
      if (c == 3) chk("skid_in_ready_drop", ir1, 0);
      if (ov1 && out_ready) got.push_back(od1);
      pi = in_valid && (mq1.size() < 2);
      mstep();
      if (pi) void'(src.pop_front());
      @(negedge clk);
    end
    chk("skid_order_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size())
        chk($sformatf("skid_order%0d", i), got[i], i + 1);

    // Flush with both entries full.
    drive(0, 1, 32'h7, 0, 1, 0, 0);
    #1; mstep(); @(negedge clk);
    drive(0, 1, 32'h8, 0, 1, 0, 0);
    #1; mstep(); @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 1, 0);
    #1;
    chk("fl_full_busy", bz1, 1);
    chk("fl_full_in_ready", ir1, 0);
    chk("fl_full_data", od1, 32'h7);
    mstep(); @(negedge clk);
    drive(0, 0, 32'h0, 1, 1, 0, 0);
    #1;
    chk("fl_after_out_valid", ov1, 0);
    chk("fl_after_busy", bz1, 0);
    chk("fl_after_in_ready", ir1, 1);
    mstep(); @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fl_no_ghost", ov1, 0);
      mstep(); @(negedge clk);
    end

    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 1) == 1,
            $urandom,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
      #1;
      mstep();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
